// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   booth_digit_t : decoded Booth digit, one-hot magnitude {zero, one, two} plus neg
//   LAT           : pipeline latency in cycles when not stalled
//   num_digits()  : number of Booth digits for an operand width
//   booth_decode(): maps a 3-bit window {y[2i+1], y[2i], y[2i-1]} to a digit
package booth_pkg;

  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
    logic zero;
  } booth_digit_t;

  // Operands are extended by two bits, so WIDTH/2 + 1 digits cover them exactly.
  function automatic int unsigned num_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    d = '{neg: 1'b0, two: 1'b0, one: 1'b0, zero: 1'b1};
    case (win)
      3'b001, 3'b010: begin d.zero = 1'b0; d.one = 1'b1; end
      3'b011:         begin d.zero = 1'b0; d.two = 1'b1; end
      3'b100:         begin d.zero = 1'b0; d.two = 1'b1; d.neg = 1'b1; end
      3'b101, 3'b110: begin d.zero = 1'b0; d.one = 1'b1; d.neg = 1'b1; end
      default:        ; // 000 and 111 are both zero; keep neg low
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Booth radix-4 partial-product row generator for one digit.
//   win_i   : digit window {y[2i+1], y[2i], y[2i-1]}
//   x_ext_i : multiplicand extended to Width+2 bits
//   pp_o    : row (digit * x_ext) << 2*Idx, ones-complemented when negative,
//             truncated to 2*Width bits
//   neg_o   : negate bit; the caller adds it at bit position 2*Idx
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Idx   = 0
) (
  input  logic [2:0]         win_i,
  input  logic [Width+1:0]   x_ext_i,
  output logic [2*Width-1:0] pp_o,
  output logic               neg_o
);

  localparam int unsigned PW = 2 * Width;

  booth_digit_t  dig;
  logic [PW-1:0] x_sx;
  logic [PW-1:0] mag;
  logic [PW-1:0] row;

  always_comb begin
    dig  = booth_decode(win_i);
    x_sx = {{(PW - Width - 2){x_ext_i[Width+1]}}, x_ext_i};
    mag  = '0;
    if (dig.one) begin
      mag = x_sx;
    end else if (dig.two) begin
      mag = x_sx << 1;
    end
    // -(m << s) == (~m << s) + (1 << s): low bits stay zero, the +1 is neg_o.
    row   = dig.neg ? ~mag : mag;
    pp_o  = row << (2 * Idx);
    neg_o = dig.neg;
  end

endmodule

// File: rtl/booth_r4_mult_pipe.sv
// Three-stage pipelined radix-4 Booth multiplier with valid/ready handshake.
//   CLK, RST            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid | out_ready)
//   mx, my              : multiplicand / multiplier, WIDTH bits
//   x_signed, y_signed  : per-operand two's-complement flags, travel with the beat
//   out_valid/out_ready : result handshake
//   sum, carry          : registered carry-save pair
//   product             : registered (sum + carry) mod 2^(2*WIDTH)
// S1 holds operands, S2 the CSA output, S3 the output registers.
module booth_r4_mult_pipe
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  input  logic               x_signed,
  input  logic               y_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned D  = num_digits(WIDTH);

  logic advance;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_mx_q, s1_mx_d, s1_my_q, s1_my_d;
  logic             s1_xs_q, s1_xs_d, s1_ys_q, s1_ys_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;

  logic             s3_valid_q, s3_valid_d;
  logic [PW-1:0]    sum_q, sum_d, carry_q, carry_d, product_q, product_d;

  // Encoding and compression between S1 and S2.
  logic [WIDTH+1:0] x_ext;
  logic [WIDTH+2:0] y_win;  // y extended by two bits with y[-1] = 0 appended
  logic [PW-1:0]    pp [D];
  logic [D-1:0]     negs;
  logic [PW-1:0]    neg_row;
  logic [PW-1:0]    csa_sum, csa_carry;

  assign x_ext = {{2{s1_xs_q & s1_mx_q[WIDTH-1]}}, s1_mx_q};
  assign y_win = {{2{s1_ys_q & s1_my_q[WIDTH-1]}}, s1_my_q, 1'b0};

  for (genvar i = 0; i < D; i++) begin : g_enc
    booth_r4_enc #(
      .Width (WIDTH),
      .Idx   (i)
    ) u_enc (
      .win_i   (y_win[2*i+2 -: 3]),
      .x_ext_i (x_ext),
      .pp_o    (pp[i]),
      .neg_o   (negs[i])
    );
  end

  // Negate bits sit at distinct even positions, so they pack into one row.
  always_comb begin
    neg_row = '0;
    for (int i = 0; i < int'(D); i++) begin
      neg_row[2*i] = negs[i];
    end
  end

  // 3:2 compressor chain over D+1 rows; each stage folds in one more row.
  for (genvar k = 0; k < D - 1; k++) begin : g_csa
    logic [PW-1:0] a, b, c, s, cy;
    if (k == 0) begin : g_first
      assign a = pp[0];
      assign b = pp[1];
      assign c = neg_row;
    end else begin : g_rest
      assign a = g_csa[k-1].s;
      assign b = g_csa[k-1].cy;
      assign c = pp[k+1];
    end
    assign s  = a ^ b ^ c;
    assign cy = ((a & b) | (a & c) | (b & c)) << 1;
  end

  assign csa_sum   = g_csa[D-2].s;
  assign csa_carry = g_csa[D-2].cy;

  assign advance  = ~s3_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mx_d    = s1_mx_q;
    s1_my_d    = s1_my_q;
    s1_xs_d    = s1_xs_q;
    s1_ys_d    = s1_ys_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s3_valid_d = s3_valid_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    product_d  = product_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_mx_d    = mx;
      s1_my_d    = my;
      s1_xs_d    = x_signed;
      s1_ys_d    = y_signed;
      s2_valid_d = s1_valid_q;
      s2_sum_d   = csa_sum;
      s2_carry_d = csa_carry;
      s3_valid_d = s2_valid_q;
      sum_d      = s2_sum_q;
      carry_d    = s2_carry_q;
      product_d  = s2_sum_q + s2_carry_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_mx_q    <= '0;
      s1_my_q    <= '0;
      s1_xs_q    <= 1'b0;
      s1_ys_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s3_valid_q <= 1'b0;
      sum_q      <= '0;
      carry_q    <= '0;
      product_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mx_q    <= s1_mx_d;
      s1_my_q    <= s1_my_d;
      s1_xs_q    <= s1_xs_d;
      s1_ys_q    <= s1_ys_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s3_valid_q <= s3_valid_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      product_q  <= product_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_r4_mult_pipe.sv
// Self-checking bench for booth_r4_mult_pipe: directed vector table, latency,
// back-pressure, mid-stream reset, random streaming and a WIDTH=16 instance.
module tb_booth_r4_mult_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready;
  logic [7:0]  mx, my;
  logic        x_signed, y_signed;
  logic        out_valid, out_ready;
  logic [15:0] sum, carry, product;

  logic        w_in_valid, w_in_ready;
  logic [15:0] w_mx, w_my;
  logic        w_xs, w_ys;
  logic        w_out_valid, w_out_ready;
  logic [31:0] w_sum, w_carry, w_product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  booth_r4_mult_pipe #(.WIDTH(8)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .x_signed  (x_signed),
    .y_signed  (y_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .product   (product)
  );

  booth_r4_mult_pipe #(.WIDTH(16)) u_dut16 (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .mx        (w_mx),
    .my        (w_my),
    .x_signed  (w_xs),
    .y_signed  (w_ys),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .sum       (w_sum),
    .carry     (w_carry),
    .product   (w_product)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        xs;
    logic        ys;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic xs, input logic ys);
    int ia, ib, p;
    ia = int'(a);
    ib = int'(b);
    if (xs && a[7]) ia -= 256;
    if (ys && b[7]) ib -= 256;
    p = ia * ib;
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample #1 later, score, then wait for posedge.
  task automatic tick(input logic rst, input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic xs, input logic ys, input logic ordy, input logic [15:0] exp);
    logic acc, fire;
    logic [15:0] e;
    @(negedge CLK);
    RST = rst; in_valid = iv; mx = a; my = b; x_signed = xs; y_signed = ys; out_ready = ordy;
    #1;
    acc  = in_valid && in_ready && !RST;
    fire = out_valid && out_ready;
    if (fire === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got product %h expected no output", product);
      end else begin
        e = exp_q.pop_front();
        check("product", {16'h0, product}, {16'h0, e});
        check("sum_plus_carry", {16'h0, 16'(sum + carry)}, {16'h0, e});
      end
    end
    if (acc === 1'b1) exp_q.push_back(exp);
    @(posedge CLK);
  endtask

  // Accept one beat, then count edges until out_valid rises.
  task automatic lat_test(input logic [7:0] a, input logic [7:0] b, input logic xs,
                          input logic ys, input logic [15:0] exp, input string name);
    int lat;
    tick(0, 1, a, b, xs, ys, 1, exp);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check(name, lat, 3);
    check({name, "_product"}, {16'h0, product}, {16'h0, exp});
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rxs, rys;
    logic [15:0] sp, ss, sc;
    int          n;

    vecs[0]  = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01};
    vecs[5]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 16'h4000};
    vecs[7]  = '{8'h80, 8'h01, 1'b1, 1'b0, 16'hFF80};
    vecs[8]  = '{8'h80, 8'hFF, 1'b0, 1'b1, 16'hFF80};
    vecs[9]  = '{8'h00, 8'hAB, 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{8'h55, 8'h03, 1'b0, 1'b0, 16'h00FF};
    vecs[11] = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080};

    RST = 1'b1; in_valid = 1'b0; mx = '0; my = '0; x_signed = 1'b0; y_signed = 1'b0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_mx = '0; w_my = '0; w_xs = 1'b0; w_ys = 1'b0; w_out_ready = 1'b1;

    // Reset state
    tick(1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    tick(1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_product", {16'h0, product}, 32'h0);
    check("reset_sum", {16'h0, sum}, 32'h0);
    check("reset_carry", {16'h0, carry}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    // Latency of a single beat: -128 * -128
    lat_test(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "latency");

    // Directed table, back to back with modes changing every beat
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, vecs[i].a, vecs[i].b, vecs[i].xs, vecs[i].ys, 1, vecs[i].exp);
    end
    repeat (6) tick(0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    check("table_drained", exp_q.size(), 0);

    // Back-pressure: 6 beats, then out_ready low for 4 cycles
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rxs = 1'($urandom); rys = 1'($urandom);
      tick(0, 1, ra, rb, rxs, rys, 1, model(ra, rb, rxs, rys));
    end
    #1;
    sp = product; ss = sum; sc = carry;
    for (int h = 0; h < 4; h++) begin
      ra = 8'($urandom); rb = 8'($urandom); rxs = 1'($urandom); rys = 1'($urandom);
      tick(0, 1, ra, rb, rxs, rys, 0, model(ra, rb, rxs, rys));
      #1;
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("hold_out_valid", {31'h0, out_valid}, 32'h1);
      check("hold_product", {16'h0, product}, {16'h0, sp});
      check("hold_sum", {16'h0, sum}, {16'h0, ss});
      check("hold_carry", {16'h0, carry}, {16'h0, sc});
    end
    repeat (8) tick(0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    check("backpressure_drained", exp_q.size(), 0);

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rxs = 1'($urandom); rys = 1'($urandom);
      tick(0, 1, ra, rb, rxs, rys, 1, model(ra, rb, rxs, rys));
    end
    tick(1, 1, 8'h12, 8'h34, 0, 0, 1, 16'h0);
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_product", {16'h0, product}, 32'h0);
    check("midrst_sum", {16'h0, sum}, 32'h0);
    check("midrst_carry", {16'h0, carry}, 32'h0);
    lat_test(8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01, "post_reset_latency");
    repeat (4) tick(0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    check("post_reset_drained", exp_q.size(), 0);

    // Random stream with bubbles and stalls
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rxs = 1'($urandom); rys = 1'($urandom);
      tick(0, ($urandom_range(3) != 0), ra, rb, rxs, rys, ($urandom_range(7) != 0),
           model(ra, rb, rxs, rys));
    end
    repeat (8) tick(0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0);
    check("random_drained", exp_q.size(), 0);

    // WIDTH=16: -32768 * 32767
    @(negedge CLK);
    w_in_valid = 1'b1; w_mx = 16'h8000; w_my = 16'h7FFF; w_xs = 1'b1; w_ys = 1'b1;
    @(posedge CLK);
    #1;
    w_in_valid = 1'b0;
    n = 1;
    while (w_out_valid !== 1'b1 && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("w16_latency", n, 3);
    check("w16_product", w_product, 32'hC0008000);
    check("w16_sum_plus_carry", w_sum + w_carry, 32'hC0008000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
